// File: rtl/iop_pkg.sv
// ---------------------------------------------------------------------------
// iop_pkg
// Shared definitions for the multichannel IOP: CPU command function codes,
// condition codes returned on iop_cc, and the per-channel state encoding.
// No ports; imported by iop_channel and iop_multichannel.
// ---------------------------------------------------------------------------
package iop_pkg;

    // CPU command function codes (iop_func); 5-7 are illegal
    localparam logic [2:0] FN_NOP = 3'd0;
    localparam logic [2:0] FN_SIO = 3'd1;
    localparam logic [2:0] FN_TIO = 3'd2;
    localparam logic [2:0] FN_HIO = 3'd3;
    localparam logic [2:0] FN_AIO = 3'd4;

    // Condition codes (iop_cc)
    localparam logic [1:0] CC_IDLE    = 2'b00;
    localparam logic [1:0] CC_BUSY    = 2'b01;
    localparam logic [1:0] CC_DONE    = 2'b10;
    localparam logic [1:0] CC_ILLEGAL = 2'b11;

    // Full-word write enables; transfers are always whole words
    localparam logic [3:0] WR_ALL = 4'hF;

    typedef enum logic [2:0] {
        CH_IDLE     = 3'd0,
        CH_FETCH    = 3'd1,
        CH_HOLD     = 3'd2,
        CH_WAIT_DEV = 3'd3,
        CH_STORE    = 3'd4,
        CH_DONE     = 3'd5
    } ch_state_e;

endpackage

// File: rtl/iop_channel.sv
// ---------------------------------------------------------------------------
// iop_channel
// One word-DMA channel: FSM, address/count registers, one-word buffer and the
// device-side valid/ready handshake.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   sio_go, start_*              start a block transfer (only honoured in IDLE)
//   halt                         HIO: return to IDLE from any state
//   ack                          AIO: leave DONE
//   grant, mem_rdata             memory cycle granted this cycle, read data
//   mem_req/mem_we/mem_addr/mem_wdata   memory request towards the arbiter
//   dev_out_*                    memory->device word handshake
//   dev_in_*                     device->memory word handshake
//   state, irq                   current state, completion interrupt level
// ---------------------------------------------------------------------------
module iop_channel
    import iop_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sio_go,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [CNT_W-1:0]  start_count,
    input  logic              start_dir,
    input  logic              halt,
    input  logic              ack,
    input  logic              grant,
    input  logic [31:0]       mem_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    output logic [31:0]       dev_out_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    input  logic [31:0]       dev_in_data,
    output ch_state_e         state,
    output logic              irq
);

    ch_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       buf_q, buf_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        buf_d   = buf_q;
        case (state_q)
            CH_IDLE: begin
                if (sio_go) begin
                    addr_d  = start_addr;
                    count_d = start_count;
                    state_d = start_dir ? CH_WAIT_DEV : CH_FETCH;
                end
            end
            CH_FETCH: begin
                if (grant) begin
                    buf_d   = mem_rdata;
                    state_d = CH_HOLD;
                end
            end
            CH_HOLD: begin
                if (dev_out_ready) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - CNT_W'(1);
                    state_d = (count_q == CNT_W'(1)) ? CH_DONE : CH_FETCH;
                end
            end
            CH_WAIT_DEV: begin
                if (dev_in_valid) begin
                    buf_d   = dev_in_data;
                    state_d = CH_STORE;
                end
            end
            CH_STORE: begin
                // The write itself is driven combinationally onto the bus
                // this cycle; here we only advance the bookkeeping.
                if (grant) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    count_d = count_q - CNT_W'(1);
                    state_d = (count_q == CNT_W'(1)) ? CH_DONE : CH_WAIT_DEV;
                end
            end
            CH_DONE: begin
                if (ack) state_d = CH_IDLE;
            end
            default: state_d = CH_IDLE;
        endcase
        // HIO wins over any transition; a memory op granted in the same cycle
        // still completes because the bus drive does not depend on halt.
        if (halt) state_d = CH_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CH_IDLE;
            addr_q  <= '0;
            count_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    assign mem_req       = (state_q == CH_FETCH) || (state_q == CH_STORE);
    assign mem_we        = (state_q == CH_STORE);
    assign mem_addr      = addr_q;
    assign mem_wdata     = buf_q;
    assign dev_out_valid = (state_q == CH_HOLD);
    assign dev_out_data  = buf_q;
    assign dev_in_ready  = (state_q == CH_WAIT_DEV);
    assign state         = state_q;
    assign irq           = (state_q == CH_DONE);

endmodule

// File: rtl/iop_multichannel.sv
// ---------------------------------------------------------------------------
// iop_multichannel
// NUM_CH independent word-DMA channels sharing one 32-bit memory port.
// Holds the CPU command decoder, the registered condition code, the
// round-robin memory arbiter and the tri-state memory bus drive.
// Ports:
//   clock, reset              clock, synchronous active-high reset
//   active                    memory bus granted to the IOP this cycle
//   mem_req                   some channel wants a memory cycle
//   memory_address/_data_out/wr_enables   bus drive, Z when !active
//   memory_data_in            read data, valid in the active cycle
//   iop_strobe/func/addr/start_addr/count/dir   CPU command
//   iop_cc                    condition code of the last command
//   irq                       per-channel completion level
//   dev_out_*, dev_in_*       per-channel device handshakes (32-bit lanes)
// ---------------------------------------------------------------------------
module iop_multichannel
    import iop_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 17,
    parameter int CNT_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   active,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      memory_address,
    input  logic [31:0]            memory_data_in,
    output logic [31:0]            memory_data_out,
    output logic [3:0]             wr_enables,
    input  logic                   iop_strobe,
    input  logic [2:0]             iop_func,
    input  logic [2:0]             iop_addr,
    input  logic [ADDR_W-1:0]      iop_start_addr,
    input  logic [CNT_W-1:0]       iop_count,
    input  logic                   iop_dir,
    output logic [1:0]             iop_cc,
    output logic [NUM_CH-1:0]      irq,
    output logic [NUM_CH-1:0]      dev_out_valid,
    input  logic [NUM_CH-1:0]      dev_out_ready,
    output logic [NUM_CH*32-1:0]   dev_out_data,
    input  logic [NUM_CH-1:0]      dev_in_valid,
    output logic [NUM_CH-1:0]      dev_in_ready,
    input  logic [NUM_CH*32-1:0]   dev_in_data
);

    localparam int RR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    ch_state_e         ch_state [NUM_CH];
    logic [ADDR_W-1:0] ch_addr  [NUM_CH];
    logic [31:0]       ch_wdata [NUM_CH];
    logic [NUM_CH-1:0] ch_req, ch_we, gnt;
    logic [NUM_CH-1:0] sio_go, halt, ack;

    logic [1:0]      cc_q, cc_d;
    logic [RR_W-1:0] rr_q, rr_d;

    // ---------------- command decode ----------------
    logic      cmd_legal;
    ch_state_e sel_state;

    assign cmd_legal = ({1'b0, iop_addr} < 4'(NUM_CH)) && (iop_func <= FN_AIO);

    always_comb begin
        sel_state = CH_IDLE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (iop_addr == 3'(i)) sel_state = ch_state[RR_W'(i)];
        end
    end

    always_comb begin
        cc_d = cc_q;
        if (iop_strobe && (iop_func != FN_NOP)) begin
            if (!cmd_legal) begin
                cc_d = CC_ILLEGAL;
            end else begin
                case (iop_func)
                    FN_SIO: begin
                        if (sel_state != CH_IDLE)  cc_d = CC_BUSY;
                        else if (iop_count == '0)  cc_d = CC_DONE;
                        else                       cc_d = CC_IDLE;
                    end
                    FN_TIO: begin
                        if (sel_state == CH_IDLE)      cc_d = CC_IDLE;
                        else if (sel_state == CH_DONE) cc_d = CC_DONE;
                        else                           cc_d = CC_BUSY;
                    end
                    FN_HIO: cc_d = ((sel_state == CH_IDLE) || (sel_state == CH_DONE)) ? CC_IDLE : CC_BUSY;
                    FN_AIO: cc_d = (sel_state == CH_DONE) ? CC_DONE : CC_IDLE;
                    default: cc_d = CC_ILLEGAL;
                endcase
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    // Search begins one past the last grantee. Reset blocks any grant so an
    // in-flight STORE cannot land during the reset cycle.
    logic [RR_W-1:0] gnt_idx;
    logic            found;
    int              idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = rr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && ch_req[RR_W'(idx)]) begin
                found   = 1'b1;
                gnt_idx = RR_W'(idx);
            end
        end
        if (found && active && !reset) gnt[gnt_idx] = 1'b1;
        rr_d = (|gnt) ? gnt_idx : rr_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cc_q <= CC_IDLE;
            rr_q <= '0;
        end else begin
            cc_q <= cc_d;
            rr_q <= rr_d;
        end
    end

    // ---------------- channels ----------------
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic hit;
            assign hit        = iop_strobe && cmd_legal && (iop_addr == 3'(gi));
            assign sio_go[gi] = hit && (iop_func == FN_SIO) && (iop_count != '0);
            assign halt[gi]   = hit && (iop_func == FN_HIO);
            assign ack[gi]    = hit && (iop_func == FN_AIO);

            iop_channel #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_ch (
                .clock         (clock),
                .reset         (reset),
                .sio_go        (sio_go[gi]),
                .start_addr    (iop_start_addr),
                .start_count   (iop_count),
                .start_dir     (iop_dir),
                .halt          (halt[gi]),
                .ack           (ack[gi]),
                .grant         (gnt[gi]),
                .mem_rdata     (memory_data_in),
                .mem_req       (ch_req[gi]),
                .mem_we        (ch_we[gi]),
                .mem_addr      (ch_addr[gi]),
                .mem_wdata     (ch_wdata[gi]),
                .dev_out_valid (dev_out_valid[gi]),
                .dev_out_ready (dev_out_ready[gi]),
                .dev_out_data  (dev_out_data[gi*32 +: 32]),
                .dev_in_valid  (dev_in_valid[gi]),
                .dev_in_ready  (dev_in_ready[gi]),
                .dev_in_data   (dev_in_data[gi*32 +: 32]),
                .state         (ch_state[gi]),
                .irq           (irq[gi])
            );
        end
    endgenerate

    // ---------------- bus drive ----------------
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_data;
    logic              bus_we;

    always_comb begin
        bus_addr = '0;
        bus_data = '0;
        bus_we   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[RR_W'(i)]) begin
                bus_addr = ch_addr[RR_W'(i)];
                bus_data = ch_wdata[RR_W'(i)];
                bus_we   = ch_we[RR_W'(i)];
            end
        end
    end

    assign mem_req         = |ch_req;
    assign memory_address  = active ? bus_addr : 'z;
    assign memory_data_out = active ? bus_data : 'z;
    assign wr_enables      = active ? (bus_we ? WR_ALL : 4'h0) : 'z;
    assign iop_cc          = cc_q;

endmodule
